// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_pkg
// Description : Shared widths, FSM state encoding and sign-extension helper
//               for the fully-connected layer schedulers.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_pkg;

    localparam int ACT_W  = 8;   // signed activation width
    localparam int WGT_W  = 8;   // signed weight width
    localparam int BIAS_W = 16;  // signed bias width
    localparam int PROD_W = 16;  // signed 8x8 product width
    localparam int ACC_W  = 23;  // accumulator, sized so NUM_IN<=64 cannot wrap
    localparam int QSHIFT = 6;   // fractional bits dropped by requantization

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_QUANT = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    // Sign-extend a 16-bit value (bias or product) to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic signed [15:0] x);
        return {{(ACC_W-16){x[15]}}, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_requant.sv
`default_nettype none
// ============================================================================
// Module      : neuron_requant
// Description : Combinational ReLU / round-half-up / saturate from the 23-bit
//               accumulator to an unsigned 0..127 activation.
// Ports       : i_acc  - signed accumulator
//               o_data - requantized activation (bit 7 always 0)
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_requant
    import layer_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [ACT_W-1:0] o_data
);

    logic [7:0] w_round;

    always_comb begin
        // 7 integer bits plus the first dropped bit as the rounding carry
        w_round = {1'b0, i_acc[QSHIFT+6:QSHIFT]} + {7'd0, i_acc[QSHIFT-1]};
        if (i_acc[ACC_W-1]) begin
            o_data = 8'd0;                       // ReLU
        end else if (|i_acc[ACC_W-2:QSHIFT+7]) begin
            o_data = 8'd127;                     // magnitude beyond 7 bits
        end else if (w_round[7]) begin
            o_data = 8'd127;                     // 127.5 rounded up to 128
        end else begin
            o_data = w_round;
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : layer_mac_scheduler
// Description : Steps one shared 8x8 signed MAC through NUM_NODES neurons of
//               NUM_IN inputs, fetching weights/bias from an external
//               synchronous ROM, and streams requantized results out.
// Ports       : clk, rst_n (async active-low)
//               act_we/act_addr/act_wdata - activation buffer write (idle only)
//               start                     - begin a layer pass (idle only)
//               w_addr/b_addr/rom_rd      - ROM request, data 1 cycle later
//               w_data/b_data             - ROM read data
//               out_valid/out_ready/out_idx/out_data - result stream
//               busy, done                - status
// Revision    : 1.0 - initial release
// ============================================================================
module layer_mac_scheduler
    import layer_pkg::*;
#(
    parameter int NUM_IN    = 15,
    parameter int NUM_NODES = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 act_we,
    input  logic [$clog2(NUM_IN)-1:0]            act_addr,
    input  logic [7:0]                           act_wdata,
    input  logic                                 start,
    output logic [$clog2(NUM_IN*NUM_NODES)-1:0]  w_addr,
    output logic [$clog2(NUM_NODES)-1:0]         b_addr,
    output logic                                 rom_rd,
    input  logic [7:0]                           w_data,
    input  logic [15:0]                          b_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(NUM_NODES)-1:0]         out_idx,
    output logic [7:0]                           out_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int AA_W = $clog2(NUM_IN);
    localparam int WA_W = $clog2(NUM_IN*NUM_NODES);
    localparam int NA_W = $clog2(NUM_NODES);
    localparam int K_W  = $clog2(NUM_IN+1);

    localparam logic [AA_W-1:0] ACT_LAST  = AA_W'(NUM_IN-1);
    localparam logic [K_W-1:0]  K_ONE     = K_W'(1);
    localparam logic [K_W-1:0]  K_LAST    = K_W'(NUM_IN);
    localparam logic [K_W-1:0]  K_PENULT  = K_W'(NUM_IN-1);
    localparam logic [NA_W-1:0] NODE_LAST = NA_W'(NUM_NODES-1);

    state_t                   state_q, state_d;
    logic signed [7:0]        act_q [NUM_IN];
    logic signed [7:0]        act_d [NUM_IN];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [NA_W-1:0]          node_q, node_d;
    logic [K_W-1:0]           k_q, k_d;
    logic [WA_W-1:0]          w_addr_q, w_addr_d;
    logic                     rom_rd_q, rom_rd_d;
    logic                     out_valid_q, out_valid_d;
    logic [NA_W-1:0]          out_idx_q, out_idx_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic signed [PROD_W-1:0] w_prod;
    logic [AA_W-1:0]          w_act_idx;
    logic [ACT_W-1:0]         w_quant;

    neuron_requant u_requant (
        .i_acc  (acc_q),
        .o_data (w_quant)
    );

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        acc_d       = acc_q;
        node_d      = node_q;
        k_d         = k_q;
        w_addr_d    = w_addr_q;
        rom_rd_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        w_act_idx   = AA_W'(k_q - K_ONE);
        w_prod      = act_q[w_act_idx] * $signed(w_data);

        case (state_q)
            ST_IDLE: begin
                if (act_we && (act_addr <= ACT_LAST)) begin
                    act_d[act_addr] = act_wdata;
                end
                if (start) begin
                    state_d  = ST_FETCH;
                    node_d   = '0;
                    busy_d   = 1'b1;
                    rom_rd_d = 1'b1;
                    w_addr_d = '0;
                end
            end
            ST_FETCH: begin
                // Issue address k=1 while the ROM returns k=0 for the first MAC
                state_d = ST_MAC;
                k_d     = K_ONE;
                if (NUM_IN > 1) begin
                    rom_rd_d = 1'b1;
                    w_addr_d = w_addr_q + WA_W'(1);
                end
            end
            ST_MAC: begin
                if (k_q == K_ONE) begin
                    acc_d = sext(b_data) + sext(w_prod);
                end else begin
                    acc_d = acc_q + sext(w_prod);
                end
                if (k_q == K_LAST) begin
                    state_d = ST_QUANT;
                end else begin
                    k_d = k_q + K_ONE;
                    // Next cycle is k+1; it still needs a read unless it is the last
                    if (k_q != K_PENULT) begin
                        rom_rd_d = 1'b1;
                        w_addr_d = w_addr_q + WA_W'(1);
                    end
                end
            end
            ST_QUANT: begin
                out_data_d  = w_quant;
                out_idx_d   = node_q;
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (node_q == NODE_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Weights are laid out node-major, so the next base is +1
                        node_d   = node_q + NA_W'(1);
                        state_d  = ST_FETCH;
                        rom_rd_d = 1'b1;
                        w_addr_d = w_addr_q + WA_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_IN; i++) begin
                act_q[i] <= '0;
            end
            acc_q       <= '0;
            node_q      <= '0;
            k_q         <= '0;
            w_addr_q    <= '0;
            rom_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            acc_q       <= acc_d;
            node_q      <= node_d;
            k_q         <= k_d;
            w_addr_q    <= w_addr_d;
            rom_rd_q    <= rom_rd_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign w_addr    = w_addr_q;
    assign b_addr    = node_q;
    assign rom_rd    = rom_rd_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_mac_scheduler
// Description : Directed bench for layer_mac_scheduler with a behavioural
//               synchronous weight/bias ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_mac_scheduler;

    localparam int NUM_IN    = 15;
    localparam int NUM_NODES = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        act_we;
    logic [3:0]  act_addr;
    logic [7:0]  act_wdata;
    logic        start;
    logic [6:0]  w_addr;
    logic [2:0]  b_addr;
    logic        rom_rd;
    logic [7:0]  w_data;
    logic [15:0] b_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    layer_mac_scheduler #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES)) dut (
        .clk(clk), .rst_n(rst_n), .act_we(act_we), .act_addr(act_addr),
        .act_wdata(act_wdata), .start(start), .w_addr(w_addr), .b_addr(b_addr),
        .rom_rd(rom_rd), .w_data(w_data), .b_data(b_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done)
    );

    logic [7:0]  wrom [NUM_IN*NUM_NODES];
    logic [15:0] brom [NUM_NODES];

    always @(posedge clk) begin
        if (rom_rd) begin
            w_data <= wrom[w_addr];
            b_data <= brom[b_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  act;
        logic [7:0]  wgt;
        logic [15:0] b0, b1, b2, brest;
        logic [7:0]  e0, e1, e2, erest;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_out [NUM_NODES];

    task automatic load(input vec_t v);
        for (int i = 0; i < NUM_IN*NUM_NODES; i++) wrom[i] = v.wgt;
        for (int i = 0; i < NUM_NODES; i++) brom[i] = v.brest;
        brom[0] = v.b0; brom[1] = v.b1; brom[2] = v.b2;
        for (int i = 0; i < NUM_NODES; i++) exp_out[i] = v.erest;
        exp_out[0] = v.e0; exp_out[1] = v.e1; exp_out[2] = v.e2;
        for (int i = 0; i < NUM_IN; i++) begin
            @(negedge clk);
            act_we = 1'b1; act_addr = 4'(i); act_wdata = v.act;
        end
        @(negedge clk);
        act_we = 1'b0;
    endtask

    task automatic set_exp_zero();
        for (int i = 0; i < NUM_NODES; i++) exp_out[i] = 8'd0;
    endtask

    // Run one layer pass and score every result. bp_node stalls the consumer
    // at that node; poke issues start/act_we while busy.
    task automatic run_layer(input int bp_node, input bit chk_time, input bit poke);
        int t0, off, got;
        bit seen_done;
        logic [2:0] h_idx;
        logic [7:0] h_data;
        got = 0; seen_done = 0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", 32'(busy), 1);
        for (int c = 0; c < 400 && !seen_done; c++) begin
            @(negedge clk);
            off = cyc - t0 + 1;
            act_we = 1'b0; start = 1'b0;
            if (poke && off == 30) begin
                start = 1'b1; act_we = 1'b1; act_addr = 4'd0; act_wdata = 8'h7F;
            end
            if (out_valid) begin
                if (got == 0 && chk_time) chk("first_valid_cycle", off, 18);
                h_idx = out_idx; h_data = out_data;
                if (out_idx == bp_node) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        chk("bp_valid_held", 32'(out_valid), 1);
                        chk("bp_idx_held", 32'(out_idx), 32'(h_idx));
                        chk("bp_data_held", 32'(out_data), 32'(h_data));
                        chk("bp_rom_rd_low", 32'(rom_rd), 0);
                    end
                    out_ready = 1'b1;
                end
                chk("out_idx", 32'(h_idx), got);
                chk("out_data", 32'(h_data), 32'(exp_out[got[2:0]]));
                got++;
                if (h_idx == bp_node) begin
                    @(negedge clk);
                    chk("bp_next_fetch_rd", 32'(rom_rd), 1);
                    chk("bp_next_fetch_b", 32'(b_addr), bp_node + 1);
                    chk("bp_next_fetch_w", 32'(w_addr), (bp_node + 1) * NUM_IN);
                end
            end
            if (done) begin
                seen_done = 1;
                chk("done_valid_low", 32'(out_valid), 0);
                if (chk_time) chk("done_cycle", off, 145);
            end
        end
        chk("result_count", got, NUM_NODES);
        chk("done_seen", 32'(seen_done), 1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_idx"},   32'(out_idx), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_rom_rd"},    32'(rom_rd), 0);
        chk({tag, "_w_addr"},    32'(w_addr), 0);
        chk({tag, "_b_addr"},    32'(b_addr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit saw_valid;
        //          act    wgt    b0       b1       b2       brest    e0  e1  e2   erest
        vecs[0] = '{8'd0,  8'd0,  16'd0,   16'd0,   16'd0,   16'd0,   0,  0,  0,   0};
        vecs[1] = '{8'd64, 8'd1,  16'd0,   16'd0,   16'd0,   16'd0,   15, 15, 15,  15};
        vecs[2] = '{8'd0,  8'd0,  16'd32,  16'hFFFF,16'd8160,16'd0,   1,  0,  127, 0};
        vecs[3] = '{8'd127,8'd127,16'd0,   16'd0,   16'd0,   16'd0,   127,127,127, 127};
        vecs[4] = '{8'hFE, 8'd3,  16'd1000,16'd1000,16'd1000,16'd1000,14, 14, 14,  14};
        vecs[5] = '{8'd10, 8'hFB, 16'd100, 16'd2000,16'd2000,16'd2000,0,  20, 20,  20};

        rst_n = 1'b0; act_we = 1'b0; act_addr = '0; act_wdata = '0;
        start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v]);
            run_layer(-1, 1'b1, 1'b0);
        end

        // Backpressure at node 3 plus ignored start/act_we while busy
        load(vecs[1]);
        run_layer(3, 1'b0, 1'b1);

        // Asynchronous reset during node 2 MAC with pokes while busy
        load(vecs[1]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        saw_valid = 0;
        while (cyc - t0 + 1 < 42) begin
            @(negedge clk);
            act_we = 1'b0; start = 1'b0;
            if (cyc - t0 + 1 == 40) begin
                start = 1'b1; act_we = 1'b1; act_addr = 4'd1; act_wdata = 8'h7F;
            end
            if (out_valid && out_idx >= 3'd2) saw_valid = 1;
        end
        act_we = 1'b0; start = 1'b0;
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_node", 32'(b_addr), 2);
        chk("no_node2_result", 32'(saw_valid), 0);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 0);
        chk("post_reset_busy", 32'(busy), 0);
        // Activation buffer was cleared, so every neuron sees bias 0 only
        set_exp_zero();
        run_layer(-1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
